// File: rtl/key_scan_pkg.sv
// Shared definitions for the key_scan front-end: filter state encoding, default timing
// constants and the lowest-set-bit helper used to form key_code.
package key_scan_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS_F = 2'd1,
        PRESSED = 2'd2,
        REL_F   = 2'd3
    } key_st_t;

    // 20 ms debounce window and 1 s long-press threshold at 50 MHz
    localparam logic [19:0] CNT_MAX_DEF  = 20'd999_999;
    localparam logic [25:0] LONG_MAX_DEF = 26'd49_999_999;

    // Index of the lowest set bit; returns 0 for an all-zero vector
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: 2-FF synchronizer, press/release filter FSM and, when KEY_LONG_EN
// is defined, a long-press counter that pulses once per hold.
module key_debounce
    import key_scan_pkg::*;
#(
    parameter logic [19:0] CNT_MAX  = CNT_MAX_DEF,
    parameter logic [25:0] LONG_MAX = LONG_MAX_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic held,
    output logic press,
`ifdef KEY_LONG_EN
    output logic long_hit,
`endif
    output logic rel
);

    localparam int CNT_W = $clog2(int'(CNT_MAX) + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 20'd1);

    logic [1:0]       sync;
    logic             sync_n;
    key_st_t          state;
    logic [CNT_W-1:0] cnt;

    // Synchronizer resets to the released level so no spurious press follows reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    assign sync_n = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            press <= 1'b0;
            rel   <= 1'b0;
        end else begin
            press <= 1'b0;
            rel   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!sync_n) begin
                        state <= PRESS_F;
                        cnt   <= '0;
                    end
                end
                PRESS_F: begin
                    if (sync_n) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= PRESSED;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (sync_n) begin
                        state <= REL_F;
                        cnt   <= '0;
                    end
                end
                REL_F: begin
                    // A low sample here is a release bounce: return silently
                    if (!sync_n) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        rel   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign held = (state == PRESSED) || (state == REL_F);

`ifdef KEY_LONG_EN
    localparam int LONG_W = $clog2(int'(LONG_MAX));
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX - 26'd1);
    localparam logic [LONG_W-1:0] LONG_PRE  = LONG_W'(LONG_MAX - 26'd2);

    logic [LONG_W-1:0] long_cnt;

    // Pauses in REL_F so a release bounce keeps the accumulated hold time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_cnt <= '0;
            long_hit <= 1'b0;
        end else begin
            long_hit <= 1'b0;
            if (!held) begin
                long_cnt <= '0;
            end else if (state == PRESSED && long_cnt != LONG_LAST) begin
                long_cnt <= long_cnt + 1'b1;
                long_hit <= (long_cnt == LONG_PRE);
            end
        end
    end
`endif

endmodule

// File: rtl/key_scan.sv
// Debounced multi-key front-end: per-key filters combined into press/release events,
// a pressed mask and the lowest pressed index. Define KEY_LONG_EN for long-press pulses.
module key_scan
    import key_scan_pkg::*;
#(
    parameter int          KEY_W    = 4,
    parameter logic [19:0] CNT_MAX  = CNT_MAX_DEF,
    parameter logic [25:0] LONG_MAX = LONG_MAX_DEF
) (
    input  logic                                        sys_clk,
    input  logic                                        sys_rst_n,
    input  logic [KEY_W-1:0]                            key_in,
    output logic                                        key_flag,
    output logic [KEY_W-1:0]                            key_value,
    output logic [(KEY_W > 1 ? $clog2(KEY_W) : 1)-1:0]  key_code,
    output logic                                        key_rel,
    output logic [KEY_W-1:0]                            key_state,
    output logic                                        key_long
);

    localparam int CODE_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

    logic [KEY_W-1:0] held;
    logic [KEY_W-1:0] press;
    logic [KEY_W-1:0] rel;
    logic [7:0]       press_pad;

`ifdef KEY_LONG_EN
    logic [KEY_W-1:0] long_hit;
`endif

    generate
        for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
            key_debounce #(
                .CNT_MAX  (CNT_MAX),
                .LONG_MAX (LONG_MAX)
            ) u_debounce (
                .clk      (sys_clk),
                .rst_n    (sys_rst_n),
                .key_n    (key_in[gi]),
                .held     (held[gi]),
                .press    (press[gi]),
`ifdef KEY_LONG_EN
                .long_hit (long_hit[gi]),
`endif
                .rel      (rel[gi])
            );
        end
    endgenerate

    assign press_pad = 8'(press);
    assign key_state = held;

    // key_value/key_code are only refreshed on a press so they hold between events
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_flag  <= 1'b0;
            key_value <= '0;
            key_code  <= '0;
            key_rel   <= 1'b0;
        end else begin
            key_flag <= |press;
            key_rel  <= |rel;
            if (|press) begin
                key_value <= press;
                key_code  <= CODE_W'(lowest_set(press_pad));
            end
        end
    end

`ifdef KEY_LONG_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_long <= 1'b0;
        end else begin
            key_long <= |long_hit;
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan (KEY_W=4, CNT_MAX=24, LONG_MAX=100): press/release vector
// table plus hand sequences for bounce, glitch, reset mid-filter and long press.
module tb_key_scan;

    localparam int LAT = 27;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] key_in = 4'hF;
    logic       key_flag;
    logic [3:0] key_value;
    logic [1:0] key_code;
    logic       key_rel;
    logic [3:0] key_state;
    logic       key_long;

    key_scan #(
        .KEY_W    (4),
        .CNT_MAX  (20'd24),
        .LONG_MAX (26'd100)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .key_flag  (key_flag),
        .key_value (key_value),
        .key_code  (key_code),
        .key_rel   (key_rel),
        .key_state (key_state),
        .key_long  (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int flag_cnt = 0;
    int rel_cnt = 0;
    int long_cnt = 0;

    always @(negedge sys_clk) begin
        if (key_flag === 1'b1) flag_cnt++;
        if (key_rel === 1'b1) rel_cnt++;
        if (key_long === 1'b1) long_cnt++;
    end

    typedef struct {
        logic [3:0] mask;
        logic [3:0] value;
        logic [1:0] code;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    // Count edges from the first sampling edge (i=0) until the chosen event; -1 on timeout
    task automatic wait_event(input int which, output int lat);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if ((which == 0 && key_flag === 1'b1) ||
                (which == 1 && key_rel === 1'b1) ||
                (which == 2 && key_long === 1'b1)) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int fs;
        int rs;
        int ls;

        vecs[0] = '{mask: 4'b0100, value: 4'b0100, code: 2'd2};
        vecs[1] = '{mask: 4'b1010, value: 4'b1010, code: 2'd1};
        vecs[2] = '{mask: 4'b0001, value: 4'b0001, code: 2'd0};
        vecs[3] = '{mask: 4'b1000, value: 4'b1000, code: 2'd3};
        vecs[4] = '{mask: 4'b1111, value: 4'b1111, code: 2'd0};
        vecs[5] = '{mask: 4'b0110, value: 4'b0110, code: 2'd1};

        // Reset state
        tick(3);
        check("rst_flag", 32'(key_flag), 0);
        check("rst_value", 32'(key_value), 0);
        check("rst_code", 32'(key_code), 0);
        check("rst_rel", 32'(key_rel), 0);
        check("rst_state", 32'(key_state), 0);
        check("rst_long", 32'(key_long), 0);
        sys_rst_n = 1'b1;
        tick(3);

        // Press/release table
        for (int v = 0; v < 6; v++) begin
            fs = flag_cnt;
            key_in = ~vecs[v].mask;
            wait_event(0, lat);
            check($sformatf("v%0d_press_lat", v), 32'(lat), LAT);
            check($sformatf("v%0d_value", v), 32'(key_value), 32'(vecs[v].value));
            check($sformatf("v%0d_code", v), 32'(key_code), 32'(vecs[v].code));
            check($sformatf("v%0d_state", v), 32'(key_state), 32'(vecs[v].mask));
            tick(1);
            check($sformatf("v%0d_flag_width", v), 32'(key_flag), 0);
            tick(30);
            check($sformatf("v%0d_hold_one_flag", v), 32'(flag_cnt - fs), 1);
            key_in = 4'hF;
            wait_event(1, lat);
            check($sformatf("v%0d_rel_lat", v), 32'(lat), LAT);
            check($sformatf("v%0d_rel_state", v), 32'(key_state), 0);
            check($sformatf("v%0d_value_hold", v), 32'(key_value), 32'(vecs[v].value));
            tick(3);
        end

        // Bounce on key 0: low 10, high 3, low 30
        fs = flag_cnt;
        rs = rel_cnt;
        key_in = 4'b1110;
        tick(10);
        key_in = 4'hF;
        tick(3);
        key_in = 4'b1110;
        wait_event(0, lat);
        check("bounce_lat", 32'(lat), LAT);
        tick(2);
        check("bounce_one_flag", 32'(flag_cnt - fs), 1);
        check("bounce_no_rel", 32'(rel_cnt - rs), 0);
        check("bounce_value", 32'(key_value), 32'(4'b0001));
        key_in = 4'hF;
        wait_event(1, lat);
        check("bounce_rel_lat", 32'(lat), LAT);
        tick(3);

        // 5-cycle release glitch while key 2 is held
        key_in = 4'b1011;
        wait_event(0, lat);
        check("glitch_press_lat", 32'(lat), LAT);
        tick(10);
        fs = flag_cnt;
        rs = rel_cnt;
        key_in = 4'hF;
        tick(5);
        key_in = 4'b1011;
        tick(40);
        check("glitch_no_rel", 32'(rel_cnt - rs), 0);
        check("glitch_no_flag", 32'(flag_cnt - fs), 0);
        check("glitch_state", 32'(key_state), 32'(4'b0100));
        key_in = 4'hF;
        wait_event(1, lat);
        check("glitch_rel_lat", 32'(lat), LAT);
        tick(3);

        // Reset mid-filter with key 3 held
        fs = flag_cnt;
        key_in = 4'b0111;
        tick(17);
        sys_rst_n = 1'b0;
        #1;
        check("midrst_flag", 32'(key_flag), 0);
        check("midrst_value", 32'(key_value), 0);
        check("midrst_code", 32'(key_code), 0);
        check("midrst_state", 32'(key_state), 0);
        check("midrst_rel", 32'(key_rel), 0);
        tick(3);
        sys_rst_n = 1'b1;
        wait_event(0, lat);
        check("midrst_lat", 32'(lat), LAT);
        check("midrst_value_after", 32'(key_value), 32'(4'b1000));
        check("midrst_code_after", 32'(key_code), 3);
        tick(2);
        check("midrst_one_flag", 32'(flag_cnt - fs), 1);
        key_in = 4'hF;
        wait_event(1, lat);
        check("midrst_rel_lat", 32'(lat), LAT);
        tick(3);

        // Long press: hold key 0 for 200 cycles
        key_in = 4'b1110;
        wait_event(0, lat);
        check("long_press_lat", 32'(lat), LAT);
        ls = long_cnt;
`ifdef KEY_LONG_EN
        // PRESSED entry is one edge before key_flag; counting restarts the edge after key_flag
        wait_event(2, lat);
        check("long_lat", 32'(lat), 100 - 2);
        tick(72);
        check("long_one_pulse", 32'(long_cnt - ls), 1);
`else
        tick(172);
        check("long_none", 32'(long_cnt - ls), 0);
`endif
        key_in = 4'hF;
        wait_event(1, lat);
        check("long_rel_lat", 32'(lat), LAT);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
